memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
Pipeline stage directly downstream of the execute stage. It takes the M-side pipeline register outputs (control, ALU result, store data) and performs the load or store on an external variable-latency data-memory port with a req/ack handshake. It handles byte, halfword and word lane steering with load sign/zero extension, and stalls the pipeline while an access is outstanding. It also enforces an access timeout and registers the results into the W pipeline register for the writeback stage.

Parameters:
TIMEOUT_CYCLES, 16, max cycles dmem_req may stay high without dmem_ack before forced completion (>=2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
RegWriteM  in  1  register write enable from execute
MemWriteM  in  1  store request
ResultSrcM  in  1  1 = load (writeback selects read data)
SizeM  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
UnsignedM  in  1  1 = zero-extend loads
RD_M  in  5  destination register
PCPlus4M  in  32  PC+4 of the instruction
WriteDataM  in  32  store data (forwarded)
ALU_ResultM  in  32  effective address / ALU result
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  32  word address {ALU_ResultM[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_rdata  in  32  read data, valid with dmem_ack
dmem_ack  in  1  access complete; only meaningful while dmem_req=1
StallM  out  1  hold PC/F/D/E/M registers
RegWriteW  out  1  registered
ResultSrcW  out  1  registered
RD_W  out  5  registered
PCPlus4W  out  32  registered
ALU_ResultW  out  32  registered
ReadDataW  out  32  registered, extended load data
MemErr  out  1  sticky error flag

Behaviour:
- Access = MemWriteM | ResultSrcM. If both are set, the access is a store; ReadDataW=0.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Misaligned access: dmem_req=0. Completes in the same cycle with no stall. W loads RegWriteW=0, ReadDataW=0. MemErr set.
- Aligned access: dmem_req=1 combinationally (gated by ~rst). dmem_we=MemWriteM.
- dmem_be:
  - byte: 1<<addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
- dmem_wdata:
  - byte: {4{WriteDataM[7:0]}}
  - half: {2{WriteDataM[15:0]}}
  - word: WriteDataM
- StallM = dmem_req & ~dmem_ack & ~timeout. Zero-wait memory (ack in the request cycle) gives no stall.
- While StallM=1, upstream holds M inputs stable. The W register loads a bubble each stalled cycle: RegWriteW=0, ResultSrcW=0; other W fields don't-care but held.
- Completion cycle (ack, or non-memory instruction, or misaligned/timeout): W register loads the M fields on that edge. Load latency is 1 cycle after ack.
- Load extraction from the lane at addr[1:0] (half: addr[1]); sign- or zero-extend per UnsignedM. Word loads pass through unchanged.
- wait_cnt (clog2(TIMEOUT_CYCLES) bits):
  - Increments on cycles with dmem_req & ~dmem_ack.
  - Clears on ack or completion.
  - timeout = dmem_req & ~dmem_ack & (wait_cnt==TIMEOUT_CYCLES-1).
- On timeout: forced completion that cycle. W loads RegWriteW=0, ReadDataW=0. MemErr set. Any later ack for that transaction is not owed by the memory.
- MemErr is sticky until rst.
- Non-access instruction: no req, passes to W in 1 cycle; ReadDataW=0.
- Reset (synchronous, active-high; also mid-stall): all W outputs 0, wait_cnt=0, MemErr=0, dmem_req=0 in the reset cycle, StallM=0.

Test Plan:
- Word load, ALU_ResultM=0x100, ack in the request cycle, rdata=0x12345678 -> StallM never high; next cycle ReadDataW=0x12345678, RegWriteW=1, ResultSrcW=1.
- Byte load addr 0x103, ack 3 cycles after req, rdata=0x80AABBCC -> StallM high 3 cycles with W bubbles (RegWriteW=0). Then ReadDataW=0xFFFFFF80; same with UnsignedM=1 -> 0x00000080.
- Half store addr 0x202, WriteDataM=0x1234ABCD -> dmem_addr=0x200, dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1. On ack: RegWriteW=0 if RegWriteM=0.
- Word load addr 0x102 -> dmem_req=0, StallM=0, MemErr=1 next cycle, RegWriteW=0, ReadDataW=0.
- Load with ack never asserted, TIMEOUT_CYCLES=16 -> StallM high exactly 15 cycles, completes on the 16th request cycle. MemErr=1, RegWriteW=0, wait_cnt back to 0.
- Assert rst during the 2nd stalled cycle of a load -> next edge: all W outputs 0, MemErr=0. dmem_req low while rst=1; after rst drops, a held access reissues dmem_req.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: pipeline stage between execute (M) and writeback (W).
// Performs loads/stores on a variable-latency req/ack data-memory port,
// steers byte/halfword/word lanes, sign/zero-extends loads, stalls the
// pipeline while an access is outstanding, and forces completion after
// TIMEOUT_CYCLES request cycles without an ack.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   RegWriteM .. ALU_ResultM       M-side pipeline register outputs
//   dmem_req/we/addr/wdata/be      memory request (combinational)
//   dmem_rdata, dmem_ack           memory response
//   StallM                         hold PC/F/D/E/M while access outstanding
//   RegWriteW .. ReadDataW         W pipeline register
//   MemErr                         sticky misalign/timeout error flag
module memory_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [1:0]  SizeM,
  input  logic        UnsignedM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        MemErr
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] r_wait_cnt;

  logic        w_access;
  logic        w_is_load;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_misaligned;
  logic        w_timeout;
  logic        w_wait;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  // A store wins when both MemWriteM and ResultSrcM are set.
  assign w_access  = MemWriteM | ResultSrcM;
  assign w_is_load = ResultSrcM & ~MemWriteM;
  assign w_is_byte = (SizeM == 2'b00);
  assign w_is_half = (SizeM == 2'b01);

  // Size 2'b11 is treated as a word.
  assign w_misaligned = w_access &
                        ((w_is_half & ALU_ResultM[0]) |
                         (~w_is_byte & ~w_is_half & (ALU_ResultM[1:0] != 2'b00)));

  assign dmem_req  = ~rst & w_access & ~w_misaligned;
  assign dmem_we   = MemWriteM;
  assign dmem_addr = {ALU_ResultM[31:2], 2'b00};

  assign w_wait    = dmem_req & ~dmem_ack;
  assign w_timeout = w_wait & (r_wait_cnt == CntMax);
  assign StallM    = w_wait & ~w_timeout;

  // Store lane steering.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = WriteDataM;
    if (w_is_byte) begin
      dmem_be    = 4'b0001 << ALU_ResultM[1:0];
      dmem_wdata = {4{WriteDataM[7:0]}};
    end else if (w_is_half) begin
      dmem_be    = ALU_ResultM[1] ? 4'b1100 : 4'b0011;
      dmem_wdata = {2{WriteDataM[15:0]}};
    end
  end

  // Load lane extraction and extension.
  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (ALU_ResultM[1:0])
      2'b00:   w_byte = dmem_rdata[7:0];
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = ALU_ResultM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    w_load_ext = dmem_rdata;
    if (w_is_byte) begin
      w_load_ext = {{24{~UnsignedM & w_byte[7]}}, w_byte};
    end else if (w_is_half) begin
      w_load_ext = {{16{~UnsignedM & w_half[15]}}, w_half};
    end
  end

  // Wait counter: runs only while stalled, so ack, timeout and any
  // non-stalled cycle all bring it back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (StallM) begin
      r_wait_cnt <= r_wait_cnt + CntW'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // W pipeline register: bubble while stalled, M fields on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      MemErr      <= 1'b0;
    end else if (StallM) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
    end else begin
      RegWriteW   <= RegWriteM & ~w_misaligned & ~w_timeout;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= (w_is_load & dmem_req & dmem_ack) ? w_load_ext : 32'h0;
      MemErr      <= MemErr | w_misaligned | w_timeout;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: table of single-instruction vectors driven
// through a memory responder with programmable ack delay; expected W
// contents are queued at issue and compared at completion. Hand-written
// sequences cover reset behaviour, including reset during a stall.
module tb_memory_stage;

  logic        clk;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM, UnsignedM;
  logic [1:0]  SizeM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        StallM, RegWriteW, ResultSrcW, MemErr;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

  memory_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .SizeM(SizeM), .UnsignedM(UnsignedM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .MemErr(MemErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we, rs, rw, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    int          ack_dly;     // cycles after issue until ack; -1 = never
    logic        exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    int          exp_stall;
    logic [31:0] exp_rd;
    logic        exp_err;     // misaligned or timeout
  } vec_t;

  typedef struct {
    logic        rw, rs;
    logic [4:0]  rd;
    logic [31:0] pc, alu, rdata;
    logic        err;
  } wexp_t;

  int    total;
  int    bad;
  logic  model_err;
  wexp_t sbq[$];
  vec_t  vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic rs, input logic rw,
                              input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int ack_dly,
                              input logic exp_req, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input int exp_stall,
                              input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.we = we; v.rs = rs; v.rw = rw; v.size = size; v.uns = uns;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.ack_dly = ack_dly;
    v.exp_req = exp_req; v.exp_be = exp_be; v.exp_wd = exp_wd;
    v.exp_stall = exp_stall; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic drive_idle();
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; SizeM = 2'b10; UnsignedM = 0;
    RD_M = '0; PCPlus4M = '0; WriteDataM = '0; ALU_ResultM = '0;
    dmem_ack = 0; dmem_rdata = 32'hDEADBEEF;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    wexp_t e, g;
    int    stalls;
    bit    done;
    bit    st;
    string tag;
    tag = $sformatf("v%0d", idx);
    RegWriteM = v.rw; MemWriteM = v.we; ResultSrcM = v.rs; SizeM = v.size;
    UnsignedM = v.uns; RD_M = 5'(idx + 1); PCPlus4M = 32'h1000 + 32'(idx * 4);
    WriteDataM = v.wdata; ALU_ResultM = v.addr;
    e.rw = v.rw & ~v.exp_err; e.rs = v.rs; e.rd = 5'(idx + 1);
    e.pc = 32'h1000 + 32'(idx * 4); e.alu = v.addr; e.rdata = v.exp_rd;
    model_err = model_err | v.exp_err;
    e.err = model_err;
    sbq.push_back(e);
    stalls = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      dmem_ack = (v.ack_dly == c);
      dmem_rdata = dmem_ack ? v.rdata : 32'hDEADBEEF;
      #1;
      if (c == 0) begin
        check({tag, " req"}, 32'(dmem_req), 32'(v.exp_req));
        if (v.exp_req) begin
          check({tag, " addr"}, dmem_addr, {v.addr[31:2], 2'b00});
          check({tag, " be"}, 32'(dmem_be), 32'(v.exp_be));
          check({tag, " we"}, 32'(dmem_we), 32'(v.we));
          if (v.we) check({tag, " wdata"}, dmem_wdata, v.exp_wd);
        end
      end
      st = StallM;
      @(posedge clk);
      #1;
      if (st) begin
        stalls++;
        check({tag, " bubble RegWriteW"}, 32'(RegWriteW), 32'd0);
      end else begin
        done = 1;
      end
    end
    dmem_ack = 0;
    if (!done) begin
      bad++;
      total++;
      $display("FAIL %s completion: no completion within 40 cycles", tag);
    end
    check({tag, " stall cycles"}, 32'(stalls), 32'(v.exp_stall));
    if (sbq.size() == 0) begin
      bad++;
      total++;
      $display("FAIL %s scoreboard: queue empty at completion", tag);
    end else begin
      g = sbq.pop_front();
      check({tag, " RegWriteW"}, 32'(RegWriteW), 32'(g.rw));
      check({tag, " ResultSrcW"}, 32'(ResultSrcW), 32'(g.rs));
      check({tag, " RD_W"}, 32'(RD_W), 32'(g.rd));
      check({tag, " PCPlus4W"}, PCPlus4W, g.pc);
      check({tag, " ALU_ResultW"}, ALU_ResultW, g.alu);
      check({tag, " ReadDataW"}, ReadDataW, g.rdata);
      check({tag, " MemErr"}, 32'(MemErr), 32'(g.err));
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    model_err = 0;

    //           we rs rw size  uns addr          wdata         rdata        ack req be       exp_wd        stl exp_rd        err
    vecs[0]  = mk(0, 0, 1, 2'b10, 0, 32'hCAFEF00D, 32'h0,       32'h0,       -1, 0, 4'b0000, 32'h0,        0, 32'h0,        0);
    vecs[1]  = mk(0, 1, 1, 2'b10, 0, 32'h0000_0100, 32'h0,      32'h12345678, 0, 1, 4'b1111, 32'h0,        0, 32'h12345678, 0);
    vecs[2]  = mk(0, 1, 1, 2'b00, 0, 32'h0000_0103, 32'h0,      32'h80AABBCC, 3, 1, 4'b1000, 32'h0,        3, 32'hFFFFFF80, 0);
    vecs[3]  = mk(0, 1, 1, 2'b00, 1, 32'h0000_0103, 32'h0,      32'h80AABBCC, 3, 1, 4'b1000, 32'h0,        3, 32'h00000080, 0);
    vecs[4]  = mk(1, 0, 0, 2'b01, 0, 32'h0000_0202, 32'h1234ABCD, 32'h0,      2, 1, 4'b1100, 32'hABCDABCD, 2, 32'h0,        0);
    vecs[5]  = mk(0, 1, 1, 2'b01, 0, 32'h0000_0102, 32'h0,      32'h80017FFF, 1, 1, 4'b1100, 32'h0,        1, 32'hFFFF8001, 0);
    vecs[6]  = mk(0, 1, 1, 2'b01, 1, 32'h0000_0100, 32'h0,      32'h80017FFF, 0, 1, 4'b0011, 32'h0,        0, 32'h00007FFF, 0);
    vecs[7]  = mk(1, 0, 0, 2'b00, 0, 32'h0000_0101, 32'h000000A5, 32'h0,      0, 1, 4'b0010, 32'hA5A5A5A5, 0, 32'h0,        0);
    vecs[8]  = mk(1, 1, 1, 2'b10, 0, 32'h0000_0300, 32'h55AA55AA, 32'hFFFFFFFF, 0, 1, 4'b1111, 32'h55AA55AA, 0, 32'h0,       0);
    vecs[9]  = mk(0, 1, 1, 2'b00, 0, 32'h0000_0101, 32'h0,      32'h00007F00, 0, 1, 4'b0010, 32'h0,        0, 32'h0000007F, 0);
    vecs[10] = mk(0, 1, 1, 2'b10, 0, 32'h0000_0102, 32'h0,      32'h11111111, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        1);
    vecs[11] = mk(0, 1, 1, 2'b10, 0, 32'h0000_0108, 32'h0,      32'h22222222, -1, 1, 4'b1111, 32'h0,      15, 32'h0,        1);
    // Reserved size behaves as word; also shows the wait counter restarted.
    vecs[12] = mk(0, 1, 1, 2'b11, 0, 32'h0000_0104, 32'h0,      32'h0BADF00D, 1, 1, 4'b1111, 32'h0,        1, 32'h0BADF00D, 0);

    // Reset with an aligned load presented: request must stay gated.
    drive_idle();
    rst = 1;
    ResultSrcM = 1; RegWriteM = 1; ALU_ResultM = 32'h100;
    @(posedge clk);
    #1;
    check("reset req gated", 32'(dmem_req), 32'd0);
    check("reset StallM", 32'(StallM), 32'd0);
    @(posedge clk);
    #1;
    check("reset RegWriteW", 32'(RegWriteW), 32'd0);
    check("reset ReadDataW", ReadDataW, 32'd0);
    check("reset PCPlus4W", PCPlus4W, 32'd0);
    check("reset MemErr", 32'(MemErr), 32'd0);
    drive_idle();
    rst = 0;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Reset during the 2nd stalled cycle of a byte load, then reissue.
    RegWriteM = 1; MemWriteM = 0; ResultSrcM = 1; SizeM = 2'b00; UnsignedM = 0;
    RD_M = 5'd9; PCPlus4M = 32'h2000; ALU_ResultM = 32'h103; WriteDataM = '0;
    dmem_ack = 0;
    #1;
    check("rst-seq first StallM", 32'(StallM), 32'd1);
    @(posedge clk);
    #1;
    rst = 1;
    #1;
    check("rst-seq req low in reset", 32'(dmem_req), 32'd0);
    check("rst-seq StallM low in reset", 32'(StallM), 32'd0);
    @(posedge clk);
    #1;
    check("rst-seq RegWriteW", 32'(RegWriteW), 32'd0);
    check("rst-seq ResultSrcW", 32'(ResultSrcW), 32'd0);
    check("rst-seq RD_W", 32'(RD_W), 32'd0);
    check("rst-seq ALU_ResultW", ALU_ResultW, 32'd0);
    check("rst-seq ReadDataW", ReadDataW, 32'd0);
    check("rst-seq MemErr cleared", 32'(MemErr), 32'd0);
    rst = 0;
    #1;
    check("rst-seq reissue req", 32'(dmem_req), 32'd1);
    check("rst-seq reissue StallM", 32'(StallM), 32'd1);
    dmem_ack = 1;
    dmem_rdata = 32'h80AABBCC;
    #1;
    check("rst-seq ack StallM", 32'(StallM), 32'd0);
    @(posedge clk);
    #1;
    dmem_ack = 0;
    check("rst-seq ReadDataW", ReadDataW, 32'hFFFFFF80);
    check("rst-seq RegWriteW", 32'(RegWriteW), 32'd1);
    check("rst-seq RD_W", 32'(RD_W), 32'd9);
    check("rst-seq MemErr stays clear", 32'(MemErr), 32'd0);

    drive_idle();
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
